// File: rtl/uart_cmd_sequencer_if.sv
// Handshake bundle between the UART receiver/transmitter, the command
// processor and the command sequencer.
interface uart_cmd_sequencer_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        timeout_err;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_busy;

  // Sequencer side
  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, timeout_err, trmt, tx_data, tx_busy
  );

  // Environment side: receiver, transmitter and command processor
  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, timeout_err, trmt, tx_data, tx_busy
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: pairs received bytes (high first) into 16-bit
// commands with an inter-byte timeout, and forwards single-byte responses
// to the transmitter.
module uart_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 52080,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_cmd_sequencer_if.slave  bus
);

  typedef enum logic {ST_HIGH, ST_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              timeout_err_q, timeout_err_d;
  logic              trmt_q, trmt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_busy_q, tx_busy_d;
  logic              consume;

  // Byte acceptance is Mealy so the receiver sees the ack in the same cycle;
  // gated by rst_n so no ack escapes while the block is held in reset.
  always_comb begin
    consume = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_HIGH: consume = bus.rx_rdy && !cmd_rdy_q;
        ST_LOW:  consume = bus.rx_rdy;
        default: consume = 1'b0;
      endcase
    end
  end

  // Next-state for the byte-pairing FSM and the independent response path.
  always_comb begin
    state_d       = state_q;
    hi_byte_d     = hi_byte_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    cmd_rdy_d     = cmd_rdy_q && !bus.clr_cmd_rdy;
    timeout_err_d = 1'b0;
    trmt_d        = 1'b0;
    tx_data_d     = tx_data_q;
    tx_busy_d     = tx_busy_q;

    case (state_q)
      ST_HIGH: begin
        // Holding off while cmd_rdy is up keeps the previous command intact.
        if (consume) begin
          hi_byte_d = bus.rx_data;
          cnt_d     = '0;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A byte arriving on the last allowed cycle still completes the command.
        if (bus.rx_rdy) begin
          cmd_d     = {hi_byte_q, bus.rx_data};
          cmd_rdy_d = 1'b1;
          state_d   = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = ST_HIGH;
        end
      end
      default: state_d = ST_HIGH;
    endcase

    // Requests during an in-flight response are dropped, not queued.
    if (bus.send_resp && !tx_busy_q) begin
      tx_data_d = bus.resp;
      trmt_d    = 1'b1;
      tx_busy_d = 1'b1;
    end else if (bus.tx_done && tx_busy_q) begin
      tx_busy_d = 1'b0;
    end
  end

  // State and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HIGH;
      hi_byte_q     <= '0;
      cnt_q         <= '0;
      cmd_q         <= '0;
      cmd_rdy_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      trmt_q        <= 1'b0;
      tx_data_q     <= '0;
      tx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_byte_q     <= hi_byte_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      cmd_rdy_q     <= cmd_rdy_d;
      timeout_err_q <= timeout_err_d;
      trmt_q        <= trmt_d;
      tx_data_q     <= tx_data_d;
      tx_busy_q     <= tx_busy_d;
    end
  end

  assign bus.clr_rx_rdy  = consume;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.trmt        = trmt_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_busy     = tx_busy_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_uart_cmd_sequencer;
  localparam int TO = 4000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cmd_sequencer_if bus();

  uart_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_clr_seen = 0;
  int n_to_seen  = 0;

  // Reference model: "is a high byte pending, and how long has it waited"
  bit          m_have_hi;
  logic [7:0]  m_hi;
  int          m_wait;
  logic [15:0] m_cmd;
  bit          m_cmd_rdy;
  bit          m_to;
  bit          m_trmt;
  logic [7:0]  m_tx_data;
  bit          m_tx_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have_hi = 0; m_hi = '0; m_wait = 0; m_cmd = '0; m_cmd_rdy = 0;
    m_to = 0; m_trmt = 0; m_tx_data = '0; m_tx_busy = 0;
  endtask

  // One clock: check outputs at negedge, advance model, act as receiver.
  task automatic cyc();
    bit exp_clr;
    bit obs_clr;
    bit set_rdy;
    @(negedge clk);
    exp_clr = bus.rx_rdy && (m_have_hi || !m_cmd_rdy);
    obs_clr = bus.clr_rx_rdy;
    if (obs_clr) n_clr_seen++;
    if (bus.timeout_err) n_to_seen++;
    chk("clr_rx_rdy", {31'b0, obs_clr}, {31'b0, exp_clr});
    chk("cmd", {16'b0, bus.cmd}, {16'b0, m_cmd});
    chk("cmd_rdy", {31'b0, bus.cmd_rdy}, {31'b0, m_cmd_rdy});
    chk("timeout_err", {31'b0, bus.timeout_err}, {31'b0, m_to});
    chk("trmt", {31'b0, bus.trmt}, {31'b0, m_trmt});
    chk("tx_data", {24'b0, bus.tx_data}, {24'b0, m_tx_data});
    chk("tx_busy", {31'b0, bus.tx_busy}, {31'b0, m_tx_busy});
    // Advance the model from the inputs present this cycle.
    m_to = 0; m_trmt = 0; set_rdy = 0;
    if (!m_have_hi) begin
      if (exp_clr) begin m_have_hi = 1; m_hi = bus.rx_data; m_wait = 0; end
    end else if (bus.rx_rdy) begin
      m_cmd = {m_hi, bus.rx_data}; set_rdy = 1; m_have_hi = 0;
    end else if (m_wait == TO - 1) begin
      m_to = 1; m_have_hi = 0;
    end else begin
      m_wait++;
    end
    m_cmd_rdy = (m_cmd_rdy && !bus.clr_cmd_rdy) || set_rdy;
    if (bus.send_resp && !m_tx_busy) begin
      m_tx_data = bus.resp; m_trmt = 1; m_tx_busy = 1;
    end else if (bus.tx_done && m_tx_busy) begin
      m_tx_busy = 0;
    end
    @(posedge clk);
    #1;
    if (obs_clr) bus.rx_rdy = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.tx_done     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    while (bus.rx_rdy && k < TO + 10) begin cyc(); k++; end
    chk("byte_consumed", {31'b0, bus.rx_rdy}, 32'd0);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic ack_cmd();
    bus.clr_cmd_rdy = 1'b1;
    cyc();
  endtask

  initial begin
    int c0;
    int t0;
    bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0; bus.resp = '0; bus.tx_done = 1'b0;
    model_reset();

    // Reset values, with a pending byte offered to prove the ack is gated.
    rst_n = 1'b0;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'hEE;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_clr_rx_rdy", {31'b0, bus.clr_rx_rdy}, 32'd0);
    chk("rst_cmd", {16'b0, bus.cmd}, 32'd0);
    chk("rst_cmd_rdy", {31'b0, bus.cmd_rdy}, 32'd0);
    chk("rst_timeout_err", {31'b0, bus.timeout_err}, 32'd0);
    chk("rst_trmt", {31'b0, bus.trmt}, 32'd0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
    chk("rst_tx_busy", {31'b0, bus.tx_busy}, 32'd0);
    bus.rx_rdy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    // 1: 0xA5, 2604-cycle gap, 0x3C
    c0 = n_clr_seen;
    send_byte(8'hA5);
    chk("t1_first_ack", n_clr_seen - c0, 32'd1);
    idle(2604);
    send_byte(8'h3C);
    chk("t1_second_ack", n_clr_seen - c0, 32'd2);
    chk("t1_cmd", {16'b0, bus.cmd}, 32'hA53C);
    chk("t1_cmd_rdy", {31'b0, bus.cmd_rdy}, 32'd1);

    // 2: backpressure while cmd_rdy is held
    c0 = n_clr_seen;
    bus.rx_data = 8'h77; bus.rx_rdy = 1'b1;
    idle(6);
    chk("t2_stalled", n_clr_seen - c0, 32'd0);
    bus.clr_cmd_rdy = 1'b1;
    cyc();
    chk("t2_no_ack_on_clr_cycle", n_clr_seen - c0, 32'd0);
    cyc();
    chk("t2_ack_after_clr", n_clr_seen - c0, 32'd1);
    send_byte(8'h11);
    chk("t2_cmd", {16'b0, bus.cmd}, 32'h7711);
    ack_cmd();

    // 3: high byte, then silence past the timeout
    t0 = n_to_seen;
    send_byte(8'h12);
    idle(TO + 20);
    chk("t3_one_timeout", n_to_seen - t0, 32'd1);
    chk("t3_cmd_kept", {16'b0, bus.cmd}, 32'h7711);
    chk("t3_cmd_rdy_low", {31'b0, bus.cmd_rdy}, 32'd0);
    send_byte(8'h56);
    send_byte(8'h78);
    chk("t3_cmd_next", {16'b0, bus.cmd}, 32'h5678);
    ack_cmd();

    // 4: low byte arrives on the last allowed cycle
    t0 = n_to_seen;
    send_byte(8'h9A);
    idle(TO - 1);
    send_byte(8'hBC);
    idle(2);
    chk("t4_no_timeout", n_to_seen - t0, 32'd0);
    chk("t4_cmd", {16'b0, bus.cmd}, 32'h9ABC);
    ack_cmd();

    // 5: response path
    bus.resp = 8'hA5; bus.send_resp = 1'b1;
    cyc();
    chk("t5_trmt", {31'b0, bus.trmt}, 32'd1);
    chk("t5_tx_data", {24'b0, bus.tx_data}, 32'hA5);
    chk("t5_tx_busy", {31'b0, bus.tx_busy}, 32'd1);
    idle(2);
    bus.resp = 8'h5A; bus.send_resp = 1'b1;
    cyc();
    chk("t5_dropped_trmt", {31'b0, bus.trmt}, 32'd0);
    chk("t5_dropped_data", {24'b0, bus.tx_data}, 32'hA5);
    bus.tx_done = 1'b1;
    cyc();
    chk("t5_busy_cleared", {31'b0, bus.tx_busy}, 32'd0);
    bus.resp = 8'h5A; bus.send_resp = 1'b1;
    cyc();
    chk("t5_second_trmt", {31'b0, bus.trmt}, 32'd1);
    chk("t5_second_data", {24'b0, bus.tx_data}, 32'h5A);
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b1;
    idle(2);

    // 6: asynchronous reset with a half-received command
    send_byte(8'h99);
    idle(3);
    t0 = n_to_seen;
    #2;
    rst_n = 1'b0;
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h44;
    #1;
    chk("t6_clr_rx_rdy", {31'b0, bus.clr_rx_rdy}, 32'd0);
    chk("t6_cmd", {16'b0, bus.cmd}, 32'd0);
    chk("t6_cmd_rdy", {31'b0, bus.cmd_rdy}, 32'd0);
    chk("t6_timeout_err", {31'b0, bus.timeout_err}, 32'd0);
    chk("t6_tx_data", {24'b0, bus.tx_data}, 32'd0);
    chk("t6_tx_busy", {31'b0, bus.tx_busy}, 32'd0);
    model_reset();
    bus.rx_rdy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t6_cmd_after", {16'b0, bus.cmd}, 32'h0102);
    chk("t6_no_timeout", n_to_seen - t0, 32'd0);
    ack_cmd();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!bus.rx_rdy && $urandom_range(0, 29) == 0) begin
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'($urandom);
      end
      bus.clr_cmd_rdy = ($urandom_range(0, 7) == 0);
      bus.send_resp   = ($urandom_range(0, 9) == 0);
      bus.resp        = 8'($urandom);
      bus.tx_done     = ($urandom_range(0, 11) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
